// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle logic/arith ops, multi-cycle multiply.
// Start/ready handshake; done pulses once per completed operation.
module param_alu #(
  parameter int DATA_W   = 8,
  parameter int MULT_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [2:0]            op,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  err
);

  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  err_q;
  logic [2*DATA_W-1:0]   result_q;

  logic [DATA_W:0]       sum;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic [2*DATA_W-1:0]   prod;
  logic [2*DATA_W-1:0]   alu_d;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // One multiplier: live operands in IDLE, captured ones while busy.
  assign mul_a = (state_q == MUL_BUSY) ? a_q : A;
  assign mul_b = (state_q == MUL_BUSY) ? b_q : B;
  assign prod  = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};

  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:  alu_d = {{(DATA_W-1){1'b0}}, sum};
      OP_SUB:  alu_d = {{(DATA_W-1){1'b0}}, diff};
      OP_AND:  alu_d = {{DATA_W{1'b0}}, A & B};
      OP_XOR:  alu_d = {{DATA_W{1'b0}}, A ^ B};
      OP_OR:   alu_d = {{DATA_W{1'b0}}, A | B};
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_NOP: ;
              OP_MUL: begin
                if (MULT_LAT == 1) begin
                  done_q   <= 1'b1;
                  result_q <= prod;
                end else begin
                  state_q <= MUL_BUSY;
                  cnt_q   <= CW'(MULT_LAT - 1);
                  ready_q <= 1'b0;
                  a_q     <= A;
                  b_q     <= B;
                end
              end
              OP_ILL: begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
              default: begin
                done_q   <= 1'b1;
                result_q <= alu_d;
              end
            endcase
          end
        end
        MUL_BUSY: begin
          if (cnt_q == CW'(1)) begin
            cnt_q    <= '0;
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            result_q <= prod;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_param_alu.sv
// Bench for param_alu: directed cases plus random traffic
// against a transaction-level reference model.
module tb_param_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // u0: DATA_W=8, MULT_LAT=3
  logic       rst0 = 1'b0, st0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic [2:0] op0 = '0;
  logic       rdy0, dn0, er0;
  logic [15:0] res0;

  param_alu #(.DATA_W(8), .MULT_LAT(3)) u0 (
    .clk(clk), .reset_n(rst0), .A(a0), .B(b0), .op(op0),
    .start(st0), .ready(rdy0), .done(dn0), .result(res0), .err(er0));

  // u1: DATA_W=16, MULT_LAT=1
  logic        rst1 = 1'b0, st1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [2:0]  op1 = '0;
  logic        rdy1, dn1, er1;
  logic [31:0] res1;

  param_alu #(.DATA_W(16), .MULT_LAT(1)) u1 (
    .clk(clk), .reset_n(rst1), .A(a1), .B(b1), .op(op1),
    .start(st1), .ready(rdy1), .done(dn1), .result(res1), .err(er1));

  // u2: DATA_W=8, MULT_LAT=8
  logic       rst2 = 1'b0, st2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic [2:0] op2 = '0;
  logic       rdy2, dn2, er2;
  logic [15:0] res2;

  param_alu #(.DATA_W(8), .MULT_LAT(8)) u2 (
    .clk(clk), .reset_n(rst2), .A(a2), .B(b2), .op(op2),
    .start(st2), .ready(rdy2), .done(dn2), .result(res2), .err(er2));

  // Reference model for u0: busy until a due edge index.
  localparam int LAT0 = 3;
  int     cyc = 0;
  bit     m_busy = 0, m_done = 0, m_err = 0;
  int     m_due = 0;
  longint m_res = 0, m_prod = 0;
  bit     chk0 = 0;

  always @(posedge clk) begin
    int a, b;
    cyc++;
    a = int'(a0);
    b = int'(b0);
    m_done = 0;
    m_err  = 0;
    if (!rst0) begin
      m_busy = 0;
      m_res  = 0;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        m_busy = 0;
        m_done = 1;
        m_res  = m_prod;
      end
    end else if (st0) begin
      case (op0)
        3'd0: ;
        3'd1: begin m_done = 1; m_res = a + b; end
        3'd2: begin m_done = 1; m_res = a & b; end
        3'd3: begin m_done = 1; m_res = a ^ b; end
        3'd5: begin
          m_done = 1;
          m_res  = (a < b ? 256 : 0) + ((a - b) & 255);
        end
        3'd6: begin m_done = 1; m_res = a | b; end
        3'd7: begin m_done = 1; m_err = 1; end
        default: begin
          m_prod = longint'(a) * longint'(b);
          m_busy = 1;
          m_due  = cyc + LAT0 - 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk0) begin
      check("m_ready", 64'(rdy0), 64'(!m_busy));
      check("m_done", 64'(dn0), 64'(m_done));
      check("m_err", 64'(er0), 64'(m_err));
      check("m_result", 64'(res0), 64'(m_res));
    end
  end

  task automatic go0(input logic [2:0] o, input logic [7:0] a,
                     input logic [7:0] b);
    op0 = o; a0 = a; b0 = b; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
  endtask

  task automatic go1(input logic [2:0] o, input logic [15:0] a,
                     input logic [15:0] b);
    op1 = o; a1 = a; b1 = b; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
  endtask

  initial begin
    int k;
    logic [15:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_ready", 64'(rdy0), 64'd1);
    check("rst_done", 64'(dn0), 64'd0);
    check("rst_result", 64'(res0), 64'd0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    chk0 = 1;

    go0(3'b001, 8'hFF, 8'h01);
    check("add_done", 64'(dn0), 64'd1);
    check("add_res", 64'(res0), 64'h0100);
    check("add_err", 64'(er0), 64'd0);
    go0(3'b101, 8'h03, 8'h05);
    check("sub_res", 64'(res0), 64'h01FE);

    go0(3'b100, 8'hFF, 8'hFF);
    check("mul_rdy_t1", 64'(rdy0), 64'd0);
    op0 = 3'b001; a0 = 8'h01; b0 = 8'h01; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    check("mul_rdy_t2", 64'(rdy0), 64'd0);
    check("mul_nodone_t2", 64'(dn0), 64'd0);
    @(negedge clk);
    check("mul_done_t3", 64'(dn0), 64'd1);
    check("mul_res", 64'(res0), 64'hFE01);
    check("mul_rdy_t3", 64'(rdy0), 64'd1);

    go0(3'b010, 8'hF0, 8'h3C);
    check("and_res", 64'(res0), 64'h0030);
    go0(3'b011, 8'hF0, 8'h3C);
    check("xor_done", 64'(dn0), 64'd1);
    check("xor_res", 64'(res0), 64'h00CC);
    go0(3'b110, 8'hF0, 8'h3C);
    check("or_done", 64'(dn0), 64'd1);
    check("or_res", 64'(res0), 64'h00FC);

    go0(3'b100, 8'hE9, 8'h14);
    repeat (2) @(negedge clk);
    check("mul1234", 64'(res0), 64'h1234);
    go0(3'b111, 8'h55, 8'hAA);
    check("ill_done", 64'(dn0), 64'd1);
    check("ill_err", 64'(er0), 64'd1);
    check("ill_res", 64'(res0), 64'h1234);
    go0(3'b000, 8'h11, 8'h22);
    check("nop_done", 64'(dn0), 64'd0);
    check("nop_res", 64'(res0), 64'h1234);

    rst0 = 1'b0;
    go0(3'b001, 8'h10, 8'h20);
    check("rst_start_done", 64'(dn0), 64'd0);
    check("rst_start_res", 64'(res0), 64'd0);
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_rel_done", 64'(dn0), 64'd0);

    for (int i = 0; i < 400; i++) begin
      rst0 = ($urandom_range(0, 59) != 0);
      st0  = ($urandom_range(0, 3) != 0);
      op0  = 3'($urandom);
      case ($urandom_range(0, 3))
        0: a0 = 8'hFF;
        1: a0 = 8'h00;
        default: a0 = 8'($urandom);
      endcase
      b0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk);
    end
    rst0 = 1'b1; st0 = 1'b0;
    repeat (4) @(negedge clk);

    go1(3'b100, 16'hFFFF, 16'h0002);
    check("w16_mul_done", 64'(dn1), 64'd1);
    check("w16_mul_res", 64'(res1), 64'h0001FFFE);
    check("w16_mul_rdy", 64'(rdy1), 64'd1);
    go1(3'b101, 16'h0000, 16'h0001);
    check("w16_sub_res", 64'(res1), 64'h0001FFFF);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      go1(3'b100, ra, rb);
      check("w16_rmul_done", 64'(dn1), 64'd1);
      check("w16_rmul_res", 64'(res1),
            64'(longint'(ra) * longint'(rb)));
      check("w16_rmul_rdy", 64'(rdy1), 64'd1);
    end

    op2 = 3'b100; a2 = 8'd3; b2 = 8'd5; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    k = 1;
    while (!dn2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("lat8_cycles", 64'(k), 64'd8);
    check("lat8_res", 64'(res2), 64'd15);
    @(negedge clk);
    check("lat8_single", 64'(dn2), 64'd0);

    op2 = 3'b100; a2 = 8'hFF; b2 = 8'hFF; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_nodone", 64'(dn2), 64'd0);
    end
    check("abort_res", 64'(res2), 64'd0);
    check("abort_rdy", 64'(rdy2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter MULT_LAT, default 3, meaning cycles from accepted multiply start to done (legal range 1..8).
REQ-003 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 The block SHALL have port A  input  DATA_W  operand A.
REQ-006 The block SHALL have port B  input  DATA_W  operand B.
REQ-007 The block SHALL have port op  input  3  opcode, sampled with start.
REQ-008 The block SHALL have port start  input  1  request, accepted only in a cycle where ready=1.
REQ-009 The block SHALL have port ready  output  1  high when a start will be accepted.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking result/err valid.
REQ-011 The block SHALL have port result  output  2*DATA_W  operation result, held until next done.
REQ-012 The block SHALL have port err  output  1  high with done for an illegal opcode, low otherwise.

Function
REQ-013 Opcodes SHALL be: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110 OR, 111 illegal.
REQ-014 A, B and op SHALL be captured on the accepting edge; later input changes SHALL NOT affect the in-flight operation.
REQ-015 ADD SHALL give zero-extended A+B; carry lands in bit DATA_W; bits above are 0.
REQ-016 SUB SHALL give (A-B) mod 2^DATA_W in bits DATA_W-1:0, borrow (A<B) in bit DATA_W, upper bits 0.
REQ-017 AND, XOR, OR SHALL give the bitwise result in low DATA_W bits, upper DATA_W bits 0.
REQ-018 MUL SHALL give the full unsigned 2*DATA_W-bit product A*B.
REQ-019 FSM states SHALL be IDLE and MUL_BUSY; reset enters IDLE.
REQ-020 IDLE: ready=1; accepted ADD/AND/XOR/SUB/OR SHALL pulse done and update result on the next edge, staying in IDLE (back-to-back single-cycle ops at one per cycle).
REQ-021 IDLE: accepted MUL SHALL enter MUL_BUSY and load a down-counter with MULT_LAT-1; ready SHALL drop in the cycle after acceptance.
REQ-022 MUL_BUSY: counter decrements each cycle; at the edge where counter reaches 0, done SHALL pulse with the product, state SHALL return to IDLE, ready SHALL rise the same cycle as done.
REQ-023 MULT_LAT=1 SHALL behave as a single-cycle op: done on the next edge, ready not dropping.
REQ-024 start while ready=0 SHALL be ignored entirely (no queueing, no err).
REQ-025 Accepted NOP SHALL produce no done and leave result and err unchanged.
REQ-026 Accepted op 111 SHALL pulse done with err=1 on the next edge, result unchanged; err SHALL be 0 on every other done.
REQ-027 done SHALL be low in every cycle not named above; it SHALL never be high two cycles for one operation.

Reset
REQ-028 While reset_n=0 at a clock edge: result=0, done=0, err=0, state=IDLE, counter=0; ready SHALL read 1 after the reset edge.
REQ-029 Reset asserted mid-multiply SHALL abort it; no done for that operation SHALL appear after reset release.
REQ-030 start coincident with reset_n=0 SHALL be ignored.

Verification
REQ-031 DATA_W=8: ADD A=0xFF B=0x01 -> next cycle done=1, result=0x0100, err=0; SUB A=0x03 B=0x05 -> result=0x01FE.
REQ-032 DATA_W=8, MULT_LAT=3: MUL A=0xFF B=0xFF at cycle t -> ready=0 cycles t+1..t+2, done=1 and result=0xFE01 at t+3, ready=1 at t+3.
REQ-033 Start ADD A=1 B=1 while MUL busy -> ignored; only the MUL done appears, result is product.
REQ-034 Back-to-back AND 0xF0&0x3C, XOR 0xF0^0x3C, OR 0xF0|0x3C on consecutive cycles -> three consecutive done pulses, results 0x0030, 0x00CC, 0x00FC.
REQ-035 op=111 after a result of 0x1234 -> done=1, err=1, result stays 0x1234; NOP -> no done.
REQ-036 DATA_W=16, MULT_LAT=1: MUL A=0xFFFF B=0x0002 -> next cycle done=1, result=0x0001FFFE; reset mid-MUL with MULT_LAT=8 -> no done after release, result=0.
